// File: rtl/bitcoin_nonce_scheduler_pkg.sv
// Shared types and constants for the nonce scheduler slice.
// The optional target comparator is enabled with the SCHED_TARGET_CMP_EN macro.
package bitcoin_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int NONCE_W = 32;
  localparam int CNT_W   = 17;

  // Index width for n cores; never zero so a single-core build still has a pointer bit.
  function automatic int core_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitcoin_nonce_scheduler_if.sv
// Hash-core array and result-memory write port bundle of the nonce scheduler.
// Handshakes: core_start/core_done are one-cycle pulses (core_hash valid with core_done); mem_we is a one-cycle write strobe with no backpressure.
interface bitcoin_nonce_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16
) ();
  logic [ADDR_W-1:0]       core_msg_addr;
  logic [NUM_CORES-1:0]    core_start;
  logic [31:0]             core_nonce;
  logic [NUM_CORES-1:0]    core_done;
  logic [32*NUM_CORES-1:0] core_hash;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [31:0]             mem_write_data;

  modport master (
    output core_msg_addr, core_start, core_nonce, mem_we, mem_addr, mem_write_data,
    input  core_done, core_hash
  );

  modport slave (
    input  core_msg_addr, core_start, core_nonce, mem_we, mem_addr, mem_write_data,
    output core_done, core_hash
  );
endinterface

// File: rtl/bitcoin_nonce_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter
  import bitcoin_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = core_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  localparam logic [IW:0] NL = (IW+1)'(N);

  logic [N-1:0] rot;
  logic [IW:0]  pos;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    // Rotate so bit 0 is the request at ptr, then map the winner back.
    rot = N'({req, req} >> ptr);
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && rot[k]) begin
        grant_valid = 1'b1;
        pos = {1'b0, ptr} + (IW+1)'(k);
        if (pos >= NL) pos = pos - NL;
        grant_idx = pos[IW-1:0];
      end
    end
    for (int k = 0; k < N; k++) begin
      grant[k] = grant_valid && (grant_idx == IW'(k));
    end
  end

endmodule

// File: rtl/bitcoin_nonce_scheduler.sv
// Nonce sweep scheduler: dispatches nonces to idle cores, captures H0, writes results round-robin.
// Define SCHED_TARGET_CMP_EN to add the target comparator (target/found/found_nonce).
module bitcoin_nonce_scheduler
  import bitcoin_sched_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int NONCE_COUNT = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              done,
  output logic              busy,
  output logic              err,
  output sched_state_t      state_dbg,
`ifdef SCHED_TARGET_CMP_EN
  input  logic [31:0]       target,
  output logic              found,
  output logic [31:0]       found_nonce,
`endif
  bitcoin_nonce_scheduler_if.master bus
);

  localparam int               CIW         = core_idx_w(NUM_CORES);
  localparam logic [CNT_W-1:0] NONCE_TOTAL = CNT_W'(NONCE_COUNT);
  localparam logic [CIW-1:0]   LAST_IDX    = CIW'(NUM_CORES - 1);

  sched_state_t state, state_n;

  logic [ADDR_W-1:0]    msg_addr_q, out_addr_q;
  logic [CNT_W-1:0]     next_nonce, issued, written;
  logic [NUM_CORES-1:0] busy_q, slot_valid;
  logic [CNT_W-1:0]     slot_nonce [NUM_CORES];
  logic [31:0]          slot_hash  [NUM_CORES];
  logic [CIW-1:0]       rr_ptr;
  logic                 err_q;

  logic                 start_acc;
  logic                 disp_valid;
  logic [NUM_CORES-1:0] disp_oh;
  logic [NUM_CORES-1:0] cap, stray, req;
  logic [NUM_CORES-1:0] grant;
  logic [CIW-1:0]       gnt_idx;
  logic                 gnt_valid;
  logic [CNT_W-1:0]     gnt_nonce;
  logic [31:0]          gnt_hash;

  always_comb begin
    state_n   = state;
    start_acc = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n   = RUN;
        start_acc = 1'b1;
      end
      RUN:  if (written == NONCE_TOTAL) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lowest-index core that is neither computing nor holding an unwritten result.
  always_comb begin
    disp_valid = 1'b0;
    disp_oh    = '0;
    if (state == RUN && issued < NONCE_TOTAL) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!disp_valid && !busy_q[i] && !slot_valid[i]) begin
          disp_valid = 1'b1;
          disp_oh[i] = 1'b1;
        end
      end
    end
  end

  assign cap   = bus.core_done & busy_q;
  assign stray = bus.core_done & ~busy_q;
  assign req   = (state == RUN) ? slot_valid : '0;

  rr_arbiter #(.N(NUM_CORES), .IW(CIW)) u_wr_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  always_comb begin
    gnt_nonce = '0;
    gnt_hash  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        gnt_nonce = slot_nonce[i];
        gnt_hash  = slot_hash[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      msg_addr_q         <= '0;
      out_addr_q         <= '0;
      next_nonce         <= '0;
      issued             <= '0;
      written            <= '0;
      busy_q             <= '0;
      slot_valid         <= '0;
      rr_ptr             <= '0;
      err_q              <= 1'b0;
      bus.core_start     <= '0;
      bus.core_nonce     <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_nonce[i] <= '0;
        slot_hash[i]  <= '0;
      end
    end else begin
      state          <= state_n;
      bus.core_start <= disp_oh;
      bus.mem_we     <= gnt_valid;
      err_q          <= start_acc ? 1'b0 : (err_q | (|stray));
      if (start_acc) begin
        msg_addr_q <= message_addr;
        out_addr_q <= output_addr;
        next_nonce <= '0;
        issued     <= '0;
        written    <= '0;
        rr_ptr     <= '0;
      end
      if (disp_valid) begin
        bus.core_nonce <= NONCE_W'(next_nonce);
        next_nonce     <= next_nonce + 1'b1;
        issued         <= issued + 1'b1;
      end
      if (gnt_valid) begin
        bus.mem_addr       <= out_addr_q + ADDR_W'(gnt_nonce);
        bus.mem_write_data <= gnt_hash;
        rr_ptr             <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        written            <= written + 1'b1;
      end
      // dispatch needs busy=0, capture busy=1, grant slot_valid=1: never the same slot twice.
      for (int i = 0; i < NUM_CORES; i++) begin
        if (disp_oh[i]) begin
          busy_q[i]     <= 1'b1;
          slot_nonce[i] <= next_nonce;
        end
        if (cap[i]) begin
          busy_q[i]     <= 1'b0;
          slot_valid[i] <= 1'b1;
          slot_hash[i]  <= bus.core_hash[32*i +: 32];
        end
        if (grant[i]) slot_valid[i] <= 1'b0;
      end
    end
  end

`ifdef SCHED_TARGET_CMP_EN
  logic [31:0] target_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q    <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
    end else if (start_acc) begin
      target_q    <= target;
      found       <= 1'b0;
      found_nonce <= '0;
    end else if (gnt_valid && !found && (gnt_hash < target_q)) begin
      found       <= 1'b1;
      found_nonce <= NONCE_W'(gnt_nonce);
    end
  end
`endif

  assign bus.core_msg_addr = msg_addr_q;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign err       = err_q;
  assign state_dbg = state;

endmodule
